// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and derived window bounds.
// Imported by the scan counter and the controller top.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int RGB565_W = 16;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_VALID_DEF = 640;
  localparam int H_FRONT_DEF = 16;

  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int H_TOTAL =
    H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
  localparam int V_TOTAL =
    V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

  localparam int H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
  localparam int H_ACT_END   = H_ACT_START + H_VALID_DEF - 1;
  localparam int V_ACT_START = V_SYNC_DEF + V_BACK_DEF;
  localparam int V_ACT_END   = V_ACT_START + V_VALID_DEF - 1;

endpackage

// File: rtl/vga_scan_cnt.sv
// Cascaded horizontal/vertical scan counters.
// cnt_v advances only when cnt_h wraps.
module vga_scan_cnt
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_v
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (cnt_h == H_LAST);
  assign v_wrap = (cnt_v == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      cnt_h <= h_wrap ? '0 : cnt_h + ONE;
      if (h_wrap)
        cnt_v <= v_wrap ? '0 : cnt_v + ONE;
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: scan counters, pixel request one cycle
// ahead, and registered hsync/vsync/rgb/frame_start.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_VALID  = H_VALID_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_VALID  = V_VALID_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int SYNC_POL = 0,
  parameter int RGB_W    = RGB565_W
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_data_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [CNT_W-1:0] H_AS =
    CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_AE =
    CNT_W'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [CNT_W-1:0] V_AS =
    CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_AE =
    CNT_W'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [CNT_W-1:0] R_HS =
    CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] R_HE =
    CNT_W'(H_SYNC + H_BACK + H_VALID - 2);
  localparam logic [CNT_W-1:0] HS_W = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_W = CNT_W'(V_SYNC);
  localparam logic POL = 1'(SYNC_POL);

  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] cnt_v;
  logic             v_act;
  logic             act;

  vga_scan_cnt #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_scan (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .cnt_h (cnt_h),
    .cnt_v (cnt_v)
  );

  assign v_act = (cnt_v >= V_AS) && (cnt_v <= V_AE);
  assign act   = (cnt_h >= H_AS) && (cnt_h <= H_AE) && v_act;

  // Request leads the active window by one column.
  assign pix_data_req = (cnt_h >= R_HS) && (cnt_h <= R_HE) && v_act;
  assign pix_x = pix_data_req ? cnt_h - R_HS : '0;
  assign pix_y = pix_data_req ? cnt_v - V_AS : '0;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      hsync       <= ~POL;
      vsync       <= ~POL;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (cnt_h < HS_W) ? POL : ~POL;
      vsync       <= (cnt_v < VS_W) ? POL : ~POL;
      rgb         <= act ? pix_data : '0;
      frame_start <= (cnt_h == '0) && (cnt_v == '0);
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl: one default-timing instance and two
// reduced-timing instances (both sync polarities) against a cycle model.
module tb_vga_ctrl;

  typedef struct packed {
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
    logic        fs;
  } obs_t;

  logic       clk;
  logic [2:0] rst_n;
  int         n_cmp;
  int         n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] pat(int px, int py, logic [15:0] s);
    logic [9:0] xx;
    logic [9:0] yy;
    xx = 10'(px);
    yy = 10'(py);
    return {yy[4:0], xx[5:0], yy[4:0]} ^ s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int HS = (g == 0) ? 96 : 8;
    localparam int HB = (g == 0) ? 48 : 6;
    localparam int HV = (g == 0) ? 640 : 20;
    localparam int HF = (g == 0) ? 16 : 4;
    localparam int VS = (g == 0) ? 2 : 2;
    localparam int VB = (g == 0) ? 33 : 3;
    localparam int VV = (g == 0) ? 480 : 6;
    localparam int VF = (g == 0) ? 10 : 2;
    localparam int POLI = (g == 2) ? 1 : 0;
    localparam logic POL = 1'(POLI);
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FR = HT * VT;

    logic [15:0] pd;
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
    logic        fs;
    logic [15:0] salt;
    obs_t        q[$];

    vga_ctrl #(
      .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
      .SYNC_POL(POLI), .RGB_W(16)
    ) dut (
      .vga_clk      (clk),
      .sys_rst_n    (rst_n[g]),
      .pix_data     (pd),
      .pix_data_req (req),
      .pix_x        (x),
      .pix_y        (y),
      .hsync        (hs),
      .vsync        (vs),
      .rgb          (rgb),
      .frame_start  (fs)
    );

    // k = clock edges since reset release; position = k mod frame.
    function automatic obs_t model(int k, bit rst);
      obs_t o;
      int p, h, v, qq, hq, vq;
      bit a;
      p = k % FR;
      h = p % HT;
      v = p / HT;
      o.req = (h >= HS + HB - 1) && (h <= HS + HB + HV - 2) &&
              (v >= VS + VB) && (v <= VS + VB + VV - 1);
      o.x = o.req ? 10'(h - (HS + HB - 1)) : 10'd0;
      o.y = o.req ? 10'(v - (VS + VB)) : 10'd0;
      if (rst) begin
        o.hs = ~POL;
        o.vs = ~POL;
        o.rgb = 16'd0;
        o.fs = 1'b0;
      end else begin
        qq = (k - 1) % FR;
        hq = qq % HT;
        vq = qq / HT;
        a = (hq >= HS + HB) && (hq < HS + HB + HV) &&
            (vq >= VS + VB) && (vq < VS + VB + VV);
        o.hs = (hq < HS) ? POL : ~POL;
        o.vs = (vq < VS) ? POL : ~POL;
        o.rgb = a ? pat(hq - HS - HB, vq - VS - VB, salt) : 16'd0;
        o.fs = (qq == 0);
      end
      return o;
    endfunction

    // Upstream picture generator: registers a pattern of the request.
    initial begin
      logic [15:0] nxt;
      salt = 16'($urandom);
      pd = '0;
      forever begin
        @(negedge clk);
        nxt = pat(int'(x), int'(y), salt);
        @(posedge clk);
        #1 pd = nxt;
      end
    end

    initial begin
      int  k;
      bit  armed;
      k = 0;
      armed = 0;
      forever begin
        @(posedge clk);
        if (rst_n[g] === 1'b0) begin
          k = 0;
          armed = 1;
          q.push_back(model(0, 1));
        end else if (armed) begin
          k++;
          q.push_back(model(k, 0));
        end
      end
    end

    initial begin
      obs_t e;
      obs_t a;
      int   cyc;
      int   last_fs;
      int   vrun;
      cyc = 0;
      last_fs = -1;
      vrun = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (q.size() > 0) begin
          e = q.pop_front();
          a = {req, x, y, hs, vs, rgb, fs};
          n_cmp++;
          if (a !== e) begin
            n_err++;
            $display("FAIL i%0d cyc%0d outputs: got req=%b x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b want req=%b x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b",
                     g, cyc, a.req, a.x, a.y, a.hs, a.vs, a.rgb, a.fs,
                     e.req, e.x, e.y, e.hs, e.vs, e.rgb, e.fs);
          end
          if (rst_n[g] === 1'b0) begin
            last_fs = -1;
            vrun = 0;
          end else begin
            if (fs === 1'b1) begin
              if (last_fs >= 0) begin
                n_cmp++;
                if (cyc - last_fs != FR) begin
                  n_err++;
                  $display("FAIL i%0d frame_period: got %0d want %0d",
                           g, cyc - last_fs, FR);
                end
              end
              last_fs = cyc;
            end
            if (vs === POL) vrun++;
            else begin
              if (vrun > 0) begin
                n_cmp++;
                if (vrun != VS * HT) begin
                  n_err++;
                  $display("FAIL i%0d vsync_width: got %0d want %0d",
                           g, vrun, VS * HT);
                end
              end
              vrun = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int r1;
    int r2;
    n_cmp = 0;
    n_err = 0;
    rst_n = 3'b000;
    r1 = 1200 + int'($urandom_range(0, 300));
    r2 = 1200 + int'($urandom_range(0, 300));
    repeat (5) @(posedge clk);
    #1 rst_n = 3'b111;
    for (int c = 0; c < 31000; c++) begin
      @(posedge clk);
      #1;
      rst_n[0] = !(c == 29200);
      rst_n[1] = !(c == r1);
      rst_n[2] = !(c == r2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA 640×480@60 Hz timing generator and pixel gate on the 25 MHz `vga_clk` domain produced by the clock-division stage. It runs the horizontal and vertical scan counters, requests pixel data from the picture generator one cycle ahead with `pix_x`/`pix_y`, and drives registered `hsync`/`vsync`/`rgb` to the DAC pins. The `rgb` output is blanked outside the active window.

## Interface
Parameters:
- `H_SYNC` 96, `H_BACK` 48, `H_VALID` 640, `H_FRONT` 16: horizontal timing in pixels (total 800).
- `V_SYNC` 2, `V_BACK` 33, `V_VALID` 480, `V_FRONT` 10: vertical timing in lines (total 525).
- `SYNC_POL` 0: active level of the sync pulses (0 = active-low).
- `RGB_W` 16: pixel width (RGB565).

Ports:
- `vga_clk` in 1: 25 MHz pixel clock, the only clock.
- `sys_rst_n` in 1: reset, synchronous, active-low, sampled on `posedge vga_clk`.
- `pix_data` in RGB_W: pixel for the coordinate requested on the previous cycle.
- `pix_data_req` out 1: coordinate request strobe.
- `pix_x` out 10: requested column, 0..639.
- `pix_y` out 10: requested row, 0..479.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `rgb` out RGB_W: pixel to the DAC, zero during blanking.
- `frame_start` out 1: one-cycle pulse in the first cycle of each frame.

## Operation
- Horizontal counter `cnt_h`:
  - Counts 0..H_TOTAL-1 (799), then wraps to 0.
  - `cnt_v` increments only on the `cnt_h` wrap; `cnt_v` counts 0..V_TOTAL-1 (524), then wraps to 0.
  - At `cnt_h`=799 and `cnt_v`=524, both counters wrap to 0 in the same cycle.
- Active window:
  - H_ACT = [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] = [144, 783].
  - V_ACT = [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] = [35, 514].
  - `act` = (`cnt_h` ∈ H_ACT) and (`cnt_v` ∈ V_ACT).
- Request (combinational from the counters):
  - `pix_data_req` = (`cnt_h` ∈ [143, 782]) and (`cnt_v` ∈ V_ACT).
  - While `pix_data_req`=1: `pix_x` = `cnt_h` − 143, `pix_y` = `cnt_v` − 35.
  - While `pix_data_req`=0: `pix_x` = `pix_y` = 0.
  - Subtraction is 10-bit unsigned and is never evaluated outside the window.
- Registered outputs, updated every cycle:
  - `hsync` ← (`cnt_h` < H_SYNC) ? SYNC_POL : ~SYNC_POL.
  - `vsync` ← (`cnt_v` < V_SYNC) ? SYNC_POL : ~SYNC_POL.
  - `rgb` ← `act` ? `pix_data` : 0.
  - `frame_start` ← (`cnt_h`==0 && `cnt_v`==0).
- The upstream picture generator must register `pix_data` from `pix_x`/`pix_y`. There is no backpressure: `pix_data` is sampled unconditionally.
- Reset (synchronous): `cnt_h`=`cnt_v`=0, `hsync`=`vsync`=~SYNC_POL, `rgb`=0, `frame_start`=0.
  - `pix_data_req`=0 and `pix_x`=`pix_y`=0 follow from the counters.
  - Reset asserted mid-frame aborts the frame. The first `frame_start` appears 1 cycle after reset release.

## Timing
- Request-to-data: coordinate at cycle t; `pix_data` valid at cycle t+1; sampled into `rgb` at the end of t+1; visible on `rgb` at t+2.
- `hsync`, `vsync` and `rgb` all share the same one-cycle register delay, so they stay mutually aligned.
- Line period: 800 cycles. Frame period: 420 000 cycles.
- Per line: 640 `pix_data_req` cycles and 640 non-zero-eligible `rgb` cycles.
- Sync pulse widths: `hsync` 96 cycles, `vsync` 2 lines (1600 cycles).

## Structure
- Package `vga_pkg` holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, H_ACT_START/END and V_ACT_START/END;
  - the RGB565 width.
- Sub-module `vga_scan_cnt` holds the cascaded `cnt_h`/`cnt_v` counters with wrap and reset. `vga_ctrl` instantiates it and adds the window decode and output registers.

## Test plan
- **Reset and first line.** Hold `sys_rst_n`=0 for 5 cycles, then release. Required: `frame_start`=1 exactly 1 cycle after release; `hsync`=0 for cycles 1–96, then 1.
- **Request window.** Required: first `pix_data_req` at `cnt_h`=143, `cnt_v`=35 with `pix_x`=0, `pix_y`=0; last at `cnt_h`=782 with `pix_x`=639; 640 requests per active line.
- **Data path.** Drive `pix_data` = {`pix_y`[4:0], `pix_x`[5:0], `pix_y`[4:0]}, registered in the bench model. Required: `rgb` equals the expected value for every active pixel and 0 in every blanking cycle, including `cnt_v`<35 and `cnt_v`>514.
- **Wrap and frame period.** Run 2 frames. Required: `frame_start` pulses exactly 420 000 cycles apart; `vsync` low for exactly 1600 cycles per frame; `cnt_v` never exceeds 524.
- **Mid-frame reset.** Assert reset at `cnt_v`=200, `cnt_h`=400 for 1 cycle. Required: next cycle `rgb`=0, `hsync`=`vsync`=1, `pix_data_req`=0; scanning restarts from (0,0).
- **Polarity.** Run with `SYNC_POL`=1. Required: `hsync`/`vsync` inverted relative to default; reset level 0.
